uart_alu_ctrl: RTL and testbench

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_pkg.sv | 21 ++
 rtl/byte_timer.sv | 37 +++
 rtl/uart_alu_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_alu_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-driven ALU controller.
package uart_alu_pkg;

    localparam int unsigned DefDbit    = 8;
    localparam int unsigned DefNbOp    = 6;
    localparam int unsigned DefTimeout = 50_000_000;

    typedef enum logic [2:0] {
        WaitA  = 3'd0,
        WaitB  = 3'd1,
        WaitOp = 3'd2,
        Exec   = 3'd3,
        Send   = 3'd4,
        WaitTx = 3'd5
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == Exec) || (s == Send) || (s == WaitTx);
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte watchdog: counts enabled cycles, saturates at TIMEOUT-1 and flags expiry.
module byte_timer #(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] Last = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != Last)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle (accepted byte) overrides expiry.
    assign o_expired = i_en && !i_clr && (cnt_q == Last);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, latches the ALU
// result and hands it to the UART transmitter; guards against stalls and overruns.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int unsigned DBIT    = DefDbit,
    parameter int unsigned NB_OP   = DefNbOp,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_opcode,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_overrun
);

    state_e           state_q, state_d;
    logic [DBIT-1:0]  data_a_q, data_a_d, data_b_q, data_b_d, tx_data_q, tx_data_d;
    logic [NB_OP-1:0] opcode_q, opcode_d;
    logic             tx_start_q, tx_start_d, busy_q, busy_d;
    logic             timeout_q, timeout_d, overrun_q, overrun_d;
    logic             rx_accept, tmr_en, tmr_clr, tmr_expired;

    assign tmr_en    = (state_q == WaitB) || (state_q == WaitOp);
    assign rx_accept = i_rx_done && !is_busy(state_q);
    assign tmr_clr   = rx_accept || !tmr_en;

    byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (tmr_clr),
        .i_en      (tmr_en),
        .o_expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        overrun_d  = overrun_q | (i_rx_done & is_busy(state_q));
        unique case (state_q)
            WaitA: begin
                if (i_rx_done) begin
                    data_a_d = i_rx_data;
                    state_d  = WaitB;
                end
            end
            WaitB: begin
                if (i_rx_done) begin
                    data_b_d = i_rx_data;
                    state_d  = WaitOp;
                end else if (tmr_expired) begin
                    state_d   = WaitA;
                    timeout_d = 1'b1;
                end
            end
            WaitOp: begin
                if (i_rx_done) begin
                    opcode_d = i_rx_data[NB_OP-1:0];
                    state_d  = Exec;
                end else if (tmr_expired) begin
                    state_d   = WaitA;
                    timeout_d = 1'b1;
                end
            end
            Exec: begin
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = Send;
            end
            Send: begin
                state_d = WaitTx;
            end
            WaitTx: begin
                if (i_tx_done) begin
                    state_d = WaitA;
                end
            end
            default: begin
                state_d = WaitA;
            end
        endcase
        busy_d = is_busy(state_d);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= WaitA;
            data_a_q   <= '0;
            data_b_q   <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_opcode   = opcode_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized self-checking bench for uart_alu_ctrl against a command-level reference model.
module tb_uart_alu_ctrl;

    localparam int unsigned DBIT    = 8;
    localparam int unsigned NB_OP   = 6;
    localparam int unsigned TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_done;
    logic [DBIT-1:0]  rx_data;
    logic [DBIT-1:0]  alu_res;
    logic             tx_done;
    logic [DBIT-1:0]  data_a, data_b, tx_data;
    logic [NB_OP-1:0] opcode;
    logic             tx_start, busy, timeout, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_tout   = 0;
    logic exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_alu_ctrl #(
        .DBIT    (DBIT),
        .NB_OP   (NB_OP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_done    (rx_done),
        .i_rx_data    (rx_data),
        .i_alu_result (alu_res),
        .i_tx_done    (tx_done),
        .o_data_a     (data_a),
        .o_data_b     (data_b),
        .o_opcode     (opcode),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_timeout    (timeout),
        .o_overrun    (overrun)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    // Combinational ALU stand-in fed by the registered operands.
    assign alu_res = alu_ref(data_a, data_b, opcode);

    // Pulse counters sampled mid-cycle, after registered outputs settle.
    always @(posedge clk) begin
        #2;
        if (tx_start) n_start = n_start + 1;
        if (timeout)  n_tout  = n_tout + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = $urandom();
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_data_a"},   data_a,   0);
        check_eq({tag, "_data_b"},   data_b,   0);
        check_eq({tag, "_opcode"},   opcode,   0);
        check_eq({tag, "_tx_start"}, tx_start, 0);
        check_eq({tag, "_tx_data"},  tx_data,  0);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_timeout"},  timeout,  0);
        check_eq({tag, "_overrun"},  overrun,  0);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input bit stray);
        send_byte(a);
        if (stray) pulse_tx_done();
        idle(gap);
        send_byte(b);
        idle(gap);
        send_byte(op);
    endtask

    // Called right after the opcode byte was sampled; expects tx_start on the next cycle.
    task automatic check_exec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int s0;
        s0 = n_start;
        check_eq("exec_busy",     busy,     1);
        check_eq("exec_opcode",   opcode,   {2'b00, op[5:0]});
        check_eq("exec_data_a",   data_a,   a);
        check_eq("exec_data_b",   data_b,   b);
        check_eq("exec_no_start", tx_start, 0);
        @(negedge clk);
        check_eq("tx_start",      tx_start, 1);
        check_eq("tx_data",       tx_data,  alu_ref(a, b, op[5:0]));
        check_eq("start_count",   n_start - s0, 1);
    endtask

    task automatic finish_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input bit inj, input int delay);
        logic [7:0] exp_data;
        exp_data = alu_ref(a, b, op[5:0]);
        idle(1);
        check_eq("start_len",  tx_start, 0);
        check_eq("waittx_busy", busy,    1);
        if (inj) begin
            send_byte($urandom());
            exp_ovr = 1'b1;
            check_eq("ovr_flag",    overrun, 1);
            check_eq("ovr_tx_data", tx_data, exp_data);
            check_eq("ovr_busy",    busy,    1);
        end
        idle(delay);
        pulse_tx_done();
        check_eq("done_busy",    busy,    0);
        check_eq("keep_data_a",  data_a,  a);
        check_eq("keep_data_b",  data_b,  b);
        check_eq("keep_opcode",  opcode,  {2'b00, op[5:0]});
        check_eq("overrun_state", overrun, exp_ovr);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int gap, input bit inj, input bit stray, input int delay);
        int t0;
        t0 = n_tout;
        send3(a, b, op, gap, stray);
        check_exec(a, b, op);
        finish_tx(a, b, op, inj, delay);
        check_eq("no_spurious_timeout", n_tout - t0, 0);
    endtask

    initial begin
        logic [5:0] codes [8];
        int t0, s0;
        logic [7:0] a, b, op;
        codes = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

        rst     = 1'b1;
        rx_done = 1'b0;
        rx_data = '0;
        tx_done = 1'b0;
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        // Basic ADD command, then opcode masking.
        run_cmd(8'h05, 8'h03, 8'h20, 0, 1'b0, 1'b0, 0);
        check_eq("add_literal", tx_data, 8'h08);
        run_cmd(8'h5A, 8'h0F, 8'hE2, 2, 1'b0, 1'b0, 3);
        check_eq("opcode_mask", opcode, 6'h22);

        // Timeout after operand A.
        t0 = n_tout;
        send_byte(8'h11);
        idle(TIMEOUT - 1);
        check_eq("to_early", timeout, 0);
        idle(1);
        check_eq("to_pulse",  timeout, 1);
        check_eq("to_busy",   busy,    0);
        check_eq("to_keep_a", data_a,  8'h11);
        idle(1);
        check_eq("to_len",    timeout, 0);
        check_eq("to_count",  n_tout - t0, 1);
        run_cmd(8'h40, 8'h07, 8'h22, 1, 1'b0, 1'b0, 1);

        // Byte arriving on the exact expiry cycle wins.
        t0 = n_tout;
        send_byte(8'h09);
        idle(TIMEOUT - 1);
        send_byte(8'h04);
        check_eq("race_timeout", timeout, 0);
        check_eq("race_data_b",  data_b,  8'h04);
        idle(1);
        send_byte(8'h20);
        check_exec(8'h09, 8'h04, 8'h20);
        finish_tx(8'h09, 8'h04, 8'h20, 1'b0, 0);
        check_eq("race_no_pulse", n_tout - t0, 0);

        // Overrun during WaitTx, then a clean command.
        run_cmd(8'h33, 8'h0C, 8'h24, 0, 1'b1, 1'b0, 2);
        run_cmd(8'h81, 8'h02, 8'h03, 3, 1'b0, 1'b0, 0);

        // Reset in WaitOp.
        send_byte(8'h12);
        send_byte(8'h34);
        s0 = n_start;
        rst = 1'b1;
        #1;
        check_zero("rst_waitop");
        exp_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        check_eq("rst_waitop_no_start", n_start - s0, 0);
        send_byte(8'h2A);
        check_eq("rst_waitop_busy", busy,   0);
        check_eq("rst_waitop_a",    data_a, 8'h2A);
        send_byte(8'h15);
        send_byte(8'h22);
        check_exec(8'h2A, 8'h15, 8'h22);
        finish_tx(8'h2A, 8'h15, 8'h22, 1'b1, 1);

        // Reset in WaitTx.
        send3(8'h77, 8'h11, 8'h26, 0, 1'b0);
        check_exec(8'h77, 8'h11, 8'h26);
        idle(1);
        s0 = n_start;
        rst = 1'b1;
        #1;
        check_zero("rst_waittx");
        exp_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        check_eq("rst_waittx_no_start", n_start - s0, 0);
        check_eq("rst_waittx_busy",     busy,         0);

        // Randomized commands.
        for (int i = 0; i < 16; i++) begin
            a  = $urandom();
            b  = $urandom();
            op = {2'($urandom()), codes[$urandom_range(0, 7)]};
            run_cmd(a, b, op, $urandom_range(0, 40), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
